// File: rtl/tiles_game_ctrl.sv
// tiles_game_ctrl: game-phase controller for the piano-tiles pipeline.
// Runs the IDLE/PLAY/FREEZE/OVER sequence and gates tile scrolling. It also
// steps the scroll speed, turns raw keycodes into single-cycle press events,
// and keeps score, lives and (optionally) the high score.
//
// Optional feature macro: TILES_HISCORE_EN
//   defined   -> high_score register, updated on entry to OVER
//   undefined -> high_score tied to 0
//
// Ports (all in the pixel_clk domain; Reset async active-high):
//   vs          vertical sync input
//   keycode     raw USB keycode, 0 = no key
//   row_done    pulse: a row left the bottom of the screen
//   hit / miss  pulses from the judge
//   frame_tick  pulse, once per frame (rising edge of vs)
//   scroll_en   scroller may advance (PLAY only)
//   speed       pixels per frame
//   tiles_clr   pulse: scroller reloads its initial pattern
//   key_valid   press event, key_code qualified by it
//   state       0 IDLE, 1 PLAY, 2 FREEZE, 3 OVER
//   score       hits, saturating at 9999
//   lives_left  remaining lives
//   high_score  best score
module tiles_game_ctrl #(
  parameter int LIVES          = 3,
  parameter int ROWS_PER_LEVEL = 5,
  parameter int SPEED_MAX      = 12,
  parameter int FREEZE_FRAMES  = 30
) (
  input  logic        pixel_clk,
  input  logic        Reset,
  input  logic        vs,
  input  logic [7:0]  keycode,
  input  logic        row_done,
  input  logic        hit,
  input  logic        miss,
  output logic        frame_tick,
  output logic        scroll_en,
  output logic [3:0]  speed,
  output logic        tiles_clr,
  output logic        key_valid,
  output logic [7:0]  key_code,
  output logic [1:0]  state,
  output logic [13:0] score,
  output logic [1:0]  lives_left,
  output logic [13:0] high_score
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_FREEZE = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
  localparam logic [7:0]  ROWS_TGT   = 8'(ROWS_PER_LEVEL);
  localparam logic [7:0]  FRZ_TGT    = 8'(FREEZE_FRAMES);
  localparam logic [4:0]  SPD_MAX5   = 5'(SPEED_MAX);
  localparam logic [13:0] SCORE_MAX  = 14'd9999;
  localparam logic [7:0]  KEY_SPACE  = 8'h2C;

  state_t      st, st_n;
  logic        vs_q, vs_qq;
  logic [7:0]  kc_q, kc_qq;
  logic        press, space_press;
  logic [7:0]  row_cnt, row_cnt_n;
  logic [7:0]  frz_cnt, frz_cnt_n;
  logic [3:0]  speed_n;
  logic [13:0] score_n;
  logic [1:0]  lives_n;
  logic        tiles_clr_n, key_valid_n;
  logic [7:0]  key_code_n;
  logic [4:0]  spd_step;
  logic        over_entry;

  // Input conditioning: vs edge detect and keycode press detect
  always_ff @(posedge pixel_clk or posedge Reset) begin
    if (Reset) begin
      vs_q       <= 1'b0;
      vs_qq      <= 1'b0;
      frame_tick <= 1'b0;
      kc_q       <= '0;
      kc_qq      <= '0;
    end else begin
      vs_q       <= vs;
      vs_qq      <= vs_q;
      frame_tick <= vs_q & ~vs_qq;
      kc_q       <= keycode;
      kc_qq      <= kc_q;
    end
  end

  // A press is a new nonzero code; a direct change between two nonzero
  // codes counts as a fresh press.
  assign press       = (kc_q != 8'd0) && (kc_q != kc_qq);
  assign space_press = press && (kc_q == KEY_SPACE);

  // State and datapath registers
  always_ff @(posedge pixel_clk or posedge Reset) begin
    if (Reset) begin
      st         <= ST_IDLE;
      speed      <= '0;
      score      <= '0;
      lives_left <= LIVES_INIT;
      row_cnt    <= '0;
      frz_cnt    <= '0;
      tiles_clr  <= 1'b0;
      key_valid  <= 1'b0;
      key_code   <= '0;
      scroll_en  <= 1'b0;
    end else begin
      st         <= st_n;
      speed      <= speed_n;
      score      <= score_n;
      lives_left <= lives_n;
      row_cnt    <= row_cnt_n;
      frz_cnt    <= frz_cnt_n;
      tiles_clr  <= tiles_clr_n;
      key_valid  <= key_valid_n;
      key_code   <= key_code_n;
      scroll_en  <= (st_n == ST_PLAY);
    end
  end

  assign state = st;

  always_comb begin
    st_n        = st;
    speed_n     = speed;
    score_n     = score;
    lives_n     = lives_left;
    row_cnt_n   = row_cnt;
    frz_cnt_n   = frz_cnt;
    tiles_clr_n = 1'b0;
    key_valid_n = 1'b0;
    key_code_n  = key_code;
    over_entry  = 1'b0;

    // Speed ladder 1 -> 2 -> 4 -> 6 ..., computed 5 bits wide then clamped
    spd_step = (speed == 4'd1) ? 5'd2 : ({1'b0, speed} + 5'd2);
    if (spd_step > SPD_MAX5) spd_step = SPD_MAX5;

    unique case (st)
      ST_IDLE: begin
        if (space_press) begin
          st_n        = ST_PLAY;
          tiles_clr_n = 1'b1;
          score_n     = '0;
          lives_n     = LIVES_INIT;
          speed_n     = 4'd1;
          row_cnt_n   = '0;
        end
      end

      ST_PLAY: begin
        if (press) begin
          key_valid_n = 1'b1;
          key_code_n  = kc_q;
        end
        if (row_done) begin
          if (row_cnt + 8'd1 == ROWS_TGT) begin
            row_cnt_n = '0;
            speed_n   = spd_step[3:0];
          end else begin
            row_cnt_n = row_cnt + 8'd1;
          end
        end
        // miss takes priority over a simultaneous hit
        if (miss) begin
          lives_n = lives_left - 2'd1;
          if (lives_left == 2'd1) begin
            st_n       = ST_OVER;
            speed_n    = '0;
            over_entry = 1'b1;
          end else begin
            st_n      = ST_FREEZE;
            frz_cnt_n = '0;
          end
        end else if (hit && (score != SCORE_MAX)) begin
          score_n = score + 14'd1;
        end
      end

      ST_FREEZE: begin
        if (frame_tick) begin
          frz_cnt_n = frz_cnt + 8'd1;
          if (frz_cnt + 8'd1 == FRZ_TGT) st_n = ST_PLAY;
        end
      end

      ST_OVER: begin
        if (space_press) st_n = ST_IDLE;
      end

      default: st_n = ST_IDLE;
    endcase
  end

`ifdef TILES_HISCORE_EN
  // score is stable on the fatal-miss cycle, so it is the final game score
  always_ff @(posedge pixel_clk or posedge Reset) begin
    if (Reset) begin
      high_score <= '0;
    end else if (over_entry && (score > high_score)) begin
      high_score <= score;
    end
  end
`else
  assign high_score = '0;
  logic unused_over_entry;
  assign unused_over_entry = over_entry;
`endif

endmodule

// File: tb/tb_tiles_game_ctrl.sv
module tb_tiles_game_ctrl;

  logic        pixel_clk = 1'b0;
  logic        Reset = 1'b1;
  logic        vs = 1'b0;
  logic [7:0]  keycode = '0;
  logic        row_done = 1'b0;
  logic        hit = 1'b0;
  logic        miss = 1'b0;
  logic        frame_tick, scroll_en, tiles_clr, key_valid;
  logic [3:0]  speed;
  logic [7:0]  key_code;
  logic [1:0]  state;
  logic [13:0] score, high_score;
  logic [1:0]  lives_left;

`ifdef TILES_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  tiles_game_ctrl #(
    .LIVES(3), .ROWS_PER_LEVEL(5), .SPEED_MAX(12), .FREEZE_FRAMES(30)
  ) dut (
    .pixel_clk(pixel_clk), .Reset(Reset), .vs(vs), .keycode(keycode),
    .row_done(row_done), .hit(hit), .miss(miss),
    .frame_tick(frame_tick), .scroll_en(scroll_en), .speed(speed),
    .tiles_clr(tiles_clr), .key_valid(key_valid), .key_code(key_code),
    .state(state), .score(score), .lives_left(lives_left),
    .high_score(high_score)
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks = 0;
  int errors = 0;
  // reference model of the game, in plain game terms
  int rows = 0;
  int hits = 0;
  int lives_m = 3;
  int hi_m = 0;
  int clr_cnt = 0;
  logic [7:0] kq[$];

  always @(negedge pixel_clk) begin
    if (tiles_clr === 1'b1) clr_cnt++;
    if (key_valid === 1'b1) kq.push_back(key_code);
  end

  // Expected speed after n completed rows in the current game
  function automatic int spd_for(int n);
    int lv = n / 5;
    if (lv == 0) return 1;
    return (2 * lv > 12) ? 12 : 2 * lv;
  endfunction

  function automatic int sat_score(int n);
    return (n > 9999) ? 9999 : n;
  endfunction

  function automatic int exp_hi();
    return HI_EN ? hi_m : 0;
  endfunction

  task automatic cyc(int n);
    repeat (n) @(negedge pixel_clk);
  endtask

  task automatic frames(int n);
    for (int i = 0; i < n; i++) begin
      vs = 1'b1; cyc(2);
      vs = 1'b0; cyc(2);
    end
  endtask

  task automatic start_game();
    keycode = 8'h2C; cyc(3);
    keycode = 8'h00; cyc(2);
    rows = 0; hits = 0; lives_m = 3;
  endtask

  task automatic add_hits(int n);
    for (int i = 0; i < n; i++) begin
      hit = 1'b1; cyc(1);
      hit = 1'b0; cyc($urandom_range(1, 3));
    end
    hits += n;
  endtask

  task automatic lose_game();
    while (lives_m > 1) begin
      miss = 1'b1; cyc(1); miss = 1'b0;
      lives_m--;
      frames(30); cyc(4);
    end
    miss = 1'b1; cyc(1); miss = 1'b0;
    lives_m = 0;
    if (sat_score(hits) > hi_m) hi_m = sat_score(hits);
    cyc(2);
  endtask

  task automatic test_reset();
    Reset = 1'b1; cyc(3);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (speed !== 4'd0) begin errors++; $display("FAIL reset_speed: got %0d expected 0", speed); end
    checks++; if (score !== 14'd0) begin errors++; $display("FAIL reset_score: got %0d expected 0", score); end
    checks++; if (lives_left !== 2'd3) begin errors++; $display("FAIL reset_lives: got %0d expected 3", lives_left); end
    checks++; if (high_score !== 14'd0) begin errors++; $display("FAIL reset_hi: got %0d expected 0", high_score); end
    checks++; if ({scroll_en, tiles_clr, key_valid, frame_tick} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b expected 0000", {scroll_en, tiles_clr, key_valid, frame_tick}); end
    checks++; if (key_code !== 8'd0) begin errors++; $display("FAIL reset_keycode: got %0h expected 0", key_code); end
    Reset = 1'b0; cyc(2);
  endtask

  task automatic test_frame_tick();
    vs = 1'b1; cyc(1);
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL ft_early: got %b expected 0", frame_tick); end
    cyc(1);
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL ft_assert: got %b expected 1", frame_tick); end
    cyc(1);
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL ft_single: got %b expected 0", frame_tick); end
    vs = 1'b0; cyc(3);
  endtask

  task automatic test_start();
    kq.delete();
    keycode = 8'h07; cyc(3); keycode = 8'h00; cyc(3);
    checks++; if (state !== 2'd0 || kq.size() != 0) begin errors++; $display("FAIL idle_ignore: got state %0d events %0d expected 0 0", state, kq.size()); end
    clr_cnt = 0;
    keycode = 8'h2C; cyc(1);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL start_latency: got %0d expected 0", state); end
    cyc(1);
    checks++; if (state !== 2'd1 || tiles_clr !== 1'b1) begin errors++; $display("FAIL start_play: got state %0d clr %b expected 1 1", state, tiles_clr); end
    checks++; if (speed !== 4'd1 || lives_left !== 2'd3 || score !== 14'd0) begin errors++; $display("FAIL start_vals: got spd %0d lives %0d score %0d expected 1 3 0", speed, lives_left, score); end
    checks++; if (scroll_en !== 1'b1) begin errors++; $display("FAIL start_scroll: got %b expected 1", scroll_en); end
    cyc(1); keycode = 8'h00; cyc(3);
    checks++; if (clr_cnt != 1 || kq.size() != 0) begin errors++; $display("FAIL start_single: got clr %0d events %0d expected 1 0", clr_cnt, kq.size()); end
    rows = 0; hits = 0; lives_m = 3;
  endtask

  task automatic test_speed_score();
    int target = 45 + $urandom_range(0, 10);
    while (rows < target) begin
      row_done = ($urandom_range(0, 2) != 0);
      hit      = ($urandom_range(0, 3) == 0);
      rows += int'(row_done);
      hits += int'(hit);
      cyc(1);
      checks++; if (speed !== 4'(spd_for(rows))) begin errors++; $display("FAIL speed rows=%0d: got %0d expected %0d", rows, speed, spd_for(rows)); end
      checks++; if (score !== 14'(sat_score(hits))) begin errors++; $display("FAIL score: got %0d expected %0d", score, sat_score(hits)); end
    end
    row_done = 1'b0; hit = 1'b0; cyc(1);
    checks++; if (state !== 2'd1 || scroll_en !== 1'b1) begin errors++; $display("FAIL play_hold: got state %0d scroll %b expected 1 1", state, scroll_en); end
  endtask

  task automatic test_keys();
    logic [7:0] seq[6];
    logic [7:0] prev;
    kq.delete();
    keycode = 8'h07; cyc(1);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL key_early: got %b expected 0", key_valid); end
    cyc(1);
    checks++; if (key_valid !== 1'b1 || key_code !== 8'h07) begin errors++; $display("FAIL key_first: got %b/%0h expected 1/07", key_valid, key_code); end
    keycode = 8'h09; cyc(2);
    checks++; if (key_valid !== 1'b1 || key_code !== 8'h09) begin errors++; $display("FAIL key_second: got %b/%0h expected 1/09", key_valid, key_code); end
    keycode = 8'h00; cyc(4);
    checks++; if (kq.size() != 2) begin errors++; $display("FAIL key_count: got %0d expected 2", kq.size()); end
    kq.delete();
    prev = 8'h00;
    for (int i = 0; i < 6; i++) begin
      do seq[i] = 8'($urandom_range(1, 255)); while (seq[i] == prev);
      prev = seq[i];
      keycode = seq[i];
      cyc($urandom_range(1, 3));
    end
    keycode = 8'h00; cyc(4);
    checks++; if (kq.size() != 6) begin errors++; $display("FAIL key_rand_count: got %0d expected 6", kq.size()); end
    for (int i = 0; i < 6 && i < kq.size(); i++) begin
      checks++; if (kq[i] !== seq[i]) begin errors++; $display("FAIL key_rand_%0d: got %0h expected %0h", i, kq[i], seq[i]); end
    end
  endtask

  task automatic test_freeze();
    bit done = 0;
    miss = 1'b1; row_done = 1'b1; cyc(1);
    miss = 1'b0; row_done = 1'b0;
    rows++; lives_m--;
    checks++; if (state !== 2'd2 || scroll_en !== 1'b0) begin errors++; $display("FAIL freeze_enter: got state %0d scroll %b expected 2 0", state, scroll_en); end
    checks++; if (lives_left !== 2'(lives_m)) begin errors++; $display("FAIL freeze_lives: got %0d expected %0d", lives_left, lives_m); end
    checks++; if (speed !== 4'(spd_for(rows))) begin errors++; $display("FAIL freeze_speed: got %0d expected %0d", speed, spd_for(rows)); end
    kq.delete();
    keycode = 8'h07; cyc(1); keycode = 8'h09; cyc(1); keycode = 8'h00;
    hit = 1'b1; row_done = 1'b1; cyc(1); hit = 1'b0; row_done = 1'b0; cyc(3);
    checks++; if (kq.size() != 0) begin errors++; $display("FAIL freeze_keys: got %0d events expected 0", kq.size()); end
    checks++; if (score !== 14'(sat_score(hits))) begin errors++; $display("FAIL freeze_hit: got %0d expected %0d", score, sat_score(hits)); end
    frames(29); cyc(8);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL freeze_early: got %0d expected 2", state); end
    vs = 1'b1;
    for (int i = 0; i < 8 && !done; i++) begin
      cyc(1);
      if (i == 1) vs = 1'b0;
      if (state === 2'd1) done = 1;
    end
    vs = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL freeze_exit: got state %0d expected 1 within 8 cycles", state); end
    checks++; if (speed !== 4'(spd_for(rows)) || scroll_en !== 1'b1) begin errors++; $display("FAIL freeze_resume: got spd %0d scroll %b expected %0d 1", speed, scroll_en, spd_for(rows)); end
    cyc(2);
  endtask

  task automatic test_game_over();
    miss = 1'b1; cyc(1); miss = 1'b0; lives_m--;
    frames(30); cyc(4);
    checks++; if (state !== 2'd1 || lives_left !== 2'(lives_m)) begin errors++; $display("FAIL last_life: got state %0d lives %0d expected 1 %0d", state, lives_left, lives_m); end
    hit = 1'b1; miss = 1'b1; cyc(1); hit = 1'b0; miss = 1'b0;
    if (sat_score(hits) > hi_m) hi_m = sat_score(hits);
    checks++; if (state !== 2'd3 || lives_left !== 2'd0) begin errors++; $display("FAIL over_enter: got state %0d lives %0d expected 3 0", state, lives_left); end
    checks++; if (score !== 14'(sat_score(hits))) begin errors++; $display("FAIL over_score: got %0d expected %0d", score, sat_score(hits)); end
    checks++; if (speed !== 4'd0 || scroll_en !== 1'b0) begin errors++; $display("FAIL over_idle: got spd %0d scroll %b expected 0 0", speed, scroll_en); end
    checks++; if (high_score !== 14'(exp_hi())) begin errors++; $display("FAIL over_hi: got %0d expected %0d", high_score, exp_hi()); end
    keycode = 8'h2C; cyc(2);
    checks++; if (state !== 2'd0 || score !== 14'(sat_score(hits))) begin errors++; $display("FAIL over_to_idle: got state %0d score %0d expected 0 %0d", state, score, sat_score(hits)); end
    keycode = 8'h00; cyc(3);
  endtask

  task automatic test_async_reset();
    start_game();
    add_hits($urandom_range(2, 6));
    #2 Reset = 1'b1;
    #1;
    hi_m = 0;
    checks++; if (state !== 2'd0 || score !== 14'd0 || speed !== 4'd0 || scroll_en !== 1'b0) begin errors++; $display("FAIL async_reset: got state %0d score %0d spd %0d scroll %b expected 0 0 0 0", state, score, speed, scroll_en); end
    checks++; if (lives_left !== 2'd3 || high_score !== 14'd0) begin errors++; $display("FAIL async_reset_regs: got lives %0d hi %0d expected 3 0", lives_left, high_score); end
    cyc(2); Reset = 1'b0; cyc(1);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL post_reset_idle: got %0d expected 0", state); end
  endtask

  task automatic test_hiscore();
    start_game(); add_hits(7); lose_game();
    checks++; if (state !== 2'd3 || high_score !== 14'(exp_hi())) begin errors++; $display("FAIL hi_first: got state %0d hi %0d expected 3 %0d", state, high_score, exp_hi()); end
    keycode = 8'h2C; cyc(3); keycode = 8'h00; cyc(2);
    start_game(); add_hits(4); lose_game();
    checks++; if (score !== 14'd4) begin errors++; $display("FAIL hi_second_score: got %0d expected 4", score); end
    checks++; if (high_score !== 14'(exp_hi())) begin errors++; $display("FAIL hi_keep: got %0d expected %0d", high_score, exp_hi()); end
    keycode = 8'h2C; cyc(3); keycode = 8'h00; cyc(2);
  endtask

  task automatic test_score_sat();
    start_game();
    hit = 1'b1; cyc(9998);
    checks++; if (score !== 14'd9998) begin errors++; $display("FAIL sat_below: got %0d expected 9998", score); end
    cyc(1);
    checks++; if (score !== 14'd9999) begin errors++; $display("FAIL sat_reach: got %0d expected 9999", score); end
    cyc(5);
    checks++; if (score !== 14'd9999) begin errors++; $display("FAIL sat_hold: got %0d expected 9999", score); end
    hit = 1'b0; cyc(2);
  endtask

  initial begin
    test_reset();
    test_frame_tick();
    test_start();
    test_speed_score();
    test_keys();
    test_freeze();
    test_game_over();
    test_async_reset();
    test_hiscore();
    test_score_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
